// File: rtl/serial_adder_arbiter.sv
// Purpose: two requesters share one bit-serial adder (two half adders plus a carry flop), granted round-robin.
// Latency: done pulses WIDTH cycles after ack; the next grant comes 2 cycles after done, so back-to-back ops repeat every WIDTH+2 cycles.
// Backpressure: req is held until its ack; requests arriving while busy stay pending and are arbitrated from IDLE.
module serial_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       ack,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             rr_last_q, rr_last_d;
    logic [1:0]       ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic ha1_s, ha1_c, ha2_c, s_bit, c_next;
    logic winner;

    assign ha1_s  = a_q[0] ^ b_q[0];
    assign ha1_c  = a_q[0] & b_q[0];
    assign s_bit  = ha1_s ^ c_q;
    assign ha2_c  = ha1_s & c_q;
    assign c_next = ha1_c | ha2_c;

    // A lone requester wins outright; rr_last only matters on a tie.
    assign winner = (req == 2'b11) ? ~rr_last_q : req[1];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        ack_d     = 2'b00;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    a_d       = winner ? a1 : a0;
                    b_d       = winner ? b1 : b0;
                    r_d       = '0;
                    c_d       = 1'b0;
                    cnt_d     = '0;
                    owner_d   = winner;
                    rr_last_d = winner;
                    ack_d     = winner ? 2'b10 : 2'b01;
                    state_d   = RUN;
                end
            end
            RUN: begin
                a_d        = a_q >> 1;
                b_d        = b_q >> 1;
                // Sum bits are written in place by bit index; same result as shifting in at the MSB.
                r_d[cnt_q] = s_bit;
                c_d        = c_next;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d     = r_d;
                    cout_d    = c_next;
                    done_id_d = owner_q;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            ack_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign ack     = ack_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;

endmodule
